prng_step_sched: RTL



---
 rtl/prng_step_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/prng_step_sched.sv
// Step/seed scheduler for the PRNG: drives clock-enable steps for the data and control
// LFSRs, handles seeding, warm-up and lock-up recovery, and arbitrates fresh bytes.
module prng_step_sched #(
   parameter logic [23:0] DATA_DIV     = 24'd10_000_000,
   parameter logic [7:0]  CTRL_RATIO   = 8'd4,
   parameter logic [7:0]  WARMUP       = 8'd32,
   parameter logic [15:0] DEFAULT_SEED = 16'h1D2C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        seed_req,
   input  logic [15:0] seed_in,
   input  logic [15:0] lfsr_word,
   input  logic [7:0]  rnd_in,
   input  logic [1:0]  req,
   output logic        data_step,
   output logic        ctrl_step,
   output logic        seed_load,
   output logic [15:0] seed_val,
   output logic [1:0]  gnt,
   output logic        rnd_valid,
   output logic [7:0]  rnd_data,
   output logic        ready,
   output logic        lock_err
);

   typedef enum logic [1:0] {S_SEED, S_WARM, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [23:0] div_q, div_d;
   logic [7:0]  ratio_q, ratio_d;
   logic [7:0]  warm_q, warm_d;
   logic        fresh_q, fresh_d;
   logic        rr_q, rr_d;
   logic        data_step_q, data_step_d;
   logic        ctrl_step_q, ctrl_step_d;
   logic        seed_load_q, seed_load_d;
   logic [15:0] seed_val_q, seed_val_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        rnd_valid_q, rnd_valid_d;
   logic [7:0]  rnd_data_q, rnd_data_d;
   logic        ready_q, ready_d;
   logic        lock_err_q, lock_err_d;
   logic        sel;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      ratio_d     = ratio_q;
      warm_d      = warm_q;
      fresh_d     = fresh_q;
      rr_d        = rr_q;
      seed_val_d  = seed_val_q;
      rnd_data_d  = rnd_data_q;
      ready_d     = ready_q;
      lock_err_d  = lock_err_q;
      data_step_d = 1'b0;
      ctrl_step_d = 1'b0;
      seed_load_d = 1'b0;
      gnt_d       = 2'b00;
      rnd_valid_d = 1'b0;
      sel         = 1'b0;
      if (ena) begin
         ready_d = (state_q == S_RUN);
         case (state_q)
            S_SEED: begin
               seed_load_d = 1'b1;
               div_d       = '0;
               ratio_d     = '0;
               warm_d      = '0;
               fresh_d     = 1'b0;
               state_d     = S_WARM;
            end
            S_WARM: begin
               if (seed_req) begin
                  seed_val_d = seed_in;
                  lock_err_d = 1'b0;
                  state_d    = S_SEED;
               end else begin
                  data_step_d = 1'b1;
                  ctrl_step_d = 1'b1;
                  if (warm_q == WARMUP - 8'd1) begin
                     warm_d  = '0;
                     fresh_d = 1'b1;
                     state_d = S_RUN;
                  end else begin
                     warm_d = warm_q + 8'd1;
                  end
               end
            end
            S_RUN: begin
               // A user reseed outranks lock-up recovery.
               if (seed_req) begin
                  seed_val_d = seed_in;
                  lock_err_d = 1'b0;
                  state_d    = S_SEED;
               end else if (lfsr_word == 16'hFFFF) begin
                  lock_err_d = 1'b1;
                  seed_val_d = DEFAULT_SEED;
                  state_d    = S_SEED;
               end else begin
                  data_step_d = (div_q == DATA_DIV - 24'd1);
                  div_d       = data_step_d ? '0 : div_q + 24'd1;
                  if (data_step_d) begin
                     ctrl_step_d = (ratio_q == CTRL_RATIO - 8'd1);
                     ratio_d     = ctrl_step_d ? '0 : ratio_q + 8'd1;
                  end
                  if (fresh_q && (req != 2'b00)) begin
                     sel         = (req == 2'b11) ? rr_q : req[1];
                     gnt_d       = sel ? 2'b10 : 2'b01;
                     rnd_valid_d = 1'b1;
                     rnd_data_d  = rnd_in;
                     rr_d        = ~sel;
                     fresh_d     = 1'b0;
                  end
                  // The byte granted alongside a step is the pre-step value, so the next one is new.
                  if (data_step_d) fresh_d = 1'b1;
               end
            end
            default: state_d = S_SEED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_SEED;
         div_q       <= '0;
         ratio_q     <= '0;
         warm_q      <= '0;
         fresh_q     <= 1'b0;
         rr_q        <= 1'b0;
         data_step_q <= 1'b0;
         ctrl_step_q <= 1'b0;
         seed_load_q <= 1'b0;
         seed_val_q  <= DEFAULT_SEED;
         gnt_q       <= 2'b00;
         rnd_valid_q <= 1'b0;
         rnd_data_q  <= '0;
         ready_q     <= 1'b0;
         lock_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         ratio_q     <= ratio_d;
         warm_q      <= warm_d;
         fresh_q     <= fresh_d;
         rr_q        <= rr_d;
         data_step_q <= data_step_d;
         ctrl_step_q <= ctrl_step_d;
         seed_load_q <= seed_load_d;
         seed_val_q  <= seed_val_d;
         gnt_q       <= gnt_d;
         rnd_valid_q <= rnd_valid_d;
         rnd_data_q  <= rnd_data_d;
         ready_q     <= ready_d;
         lock_err_q  <= lock_err_d;
      end
   end

   assign data_step = data_step_q;
   assign ctrl_step = ctrl_step_q;
   assign seed_load = seed_load_q;
   assign seed_val  = seed_val_q;
   assign gnt       = gnt_q;
   assign rnd_valid = rnd_valid_q;
   assign rnd_data  = rnd_data_q;
   assign ready     = ready_q;
   assign lock_err  = lock_err_q;

endmodule
